hwpe_stream_fifo_drain_arbiter: RTL and testbench

Round-robin burst arbiter that drains NB_IN HWPE-Stream sources, typically the pop side of NB_IN hwpe_stream_fifo instances, into one shared output stream. It grants one source at a time for a burst of up to BURST_LEN beats, then hands over to the next requesting source. It sits between per-requester FIFOs and a single consumer, such as a streamer sink or a TCDM write port.

---
 rtl/hwpe_stream_package.sv | 15 +
 rtl/hwpe_stream_intf_stream.sv | 16 +
 rtl/hwpe_stream_rr_pick.sv | 35 +++
 rtl/hwpe_stream_fifo_drain_arbiter.sv | 146 ++++++++++++++
 tb/tb_hwpe_stream_fifo_drain_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE-Stream drain arbiter: status flags and FSM state.
package hwpe_stream_package;

  typedef struct packed {
    logic       busy;
    logic [7:0] grant;
    logic [7:0] burst_cnt;
  } flags_arb_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream handshake bundle. A beat transfers when valid and ready are both high
// in the same cycle; a source holds valid/data/strb stable until that beat.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_rr_pick.sv
// Rotating-priority search: first requesting index at or after start (mod NB_IN),
// optionally skipping one excluded index.
module hwpe_stream_rr_pick #(
  parameter int unsigned NB_IN = 2,
  localparam int unsigned GW = (NB_IN > 1) ? $clog2(NB_IN) : 1
) (
  input  logic [NB_IN-1:0] req,
  input  logic [GW-1:0]    start,
  input  logic             excl_en,
  input  logic [GW-1:0]    excl,
  output logic             found,
  output logic [GW-1:0]    idx
);

  int          j_int;
  logic [GW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j_int = 0;
    j     = '0;
    for (int k = 0; k < int'(NB_IN); k++) begin
      // Explicit wrap so non-power-of-two NB_IN never indexes past the last source.
      j_int = int'(start) + k;
      if (j_int >= int'(NB_IN)) j_int = j_int - int'(NB_IN);
      j = GW'(j_int);
      if (!found && req[j] && !(excl_en && (j == excl))) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_fifo_drain_arbiter.sv
// Round-robin burst arbiter merging NB_IN HWPE-Stream sources into one output,
// granting one source for up to BURST_LEN beats with zero-bubble handover.
module hwpe_stream_fifo_drain_arbiter
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_IN      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  hwpe_stream_intf_stream.sink   push_i [NB_IN-1:0],
  hwpe_stream_intf_stream.source pop_o,
  output flags_arb_t             flags_o
);

  localparam int unsigned GW = (NB_IN > 1) ? $clog2(NB_IN) : 1;
  localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NB_IN - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] rr_q, rr_d;

  logic [NB_IN-1:0]      req;
  logic [NB_IN-1:0]      rdy;
  logic [DATA_WIDTH-1:0] dat [NB_IN];
  logic [STRB_WIDTH-1:0] stb [NB_IN];

  logic                  pop_valid;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [STRB_WIDTH-1:0] pop_strb;
  logic                  beat;

  logic [GW-1:0] grant_inc;
  logic [GW-1:0] pick_start;
  logic          pick_excl_en;
  logic          pick_found;
  logic [GW-1:0] pick_idx;

  for (genvar i = 0; i < int'(NB_IN); i++) begin : g_unpack
    assign req[i]         = push_i[i].valid;
    assign dat[i]         = push_i[i].data;
    assign stb[i]         = push_i[i].strb;
    assign push_i[i].ready = rdy[i];
  end

  assign grant_inc = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  // One search engine serves both IDLE arbitration and burst-end handover.
  assign pick_start   = (state_q == ARB_BURST) ? grant_inc : rr_q;
  assign pick_excl_en = (state_q == ARB_BURST);

  hwpe_stream_rr_pick #(
    .NB_IN (NB_IN)
  ) i_rr_pick (
    .req     (req),
    .start   (pick_start),
    .excl_en (pick_excl_en),
    .excl    (grant_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    rdy       = '0;
    pop_valid = 1'b0;
    pop_data  = '0;
    pop_strb  = '0;
    beat      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        pop_valid    = req[grant_q];
        rdy[grant_q] = pop_o.ready;
        if (req[grant_q]) begin
          pop_data = dat[grant_q];
          pop_strb = stb[grant_q];
        end
        beat = req[grant_q] & pop_o.ready;
        if (!req[grant_q]) begin
          rr_d    = grant_inc;
          cnt_d   = '0;
          state_d = ARB_IDLE;
        end else if (beat) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Current source is still valid here, so it is the fallback winner.
            rr_d    = grant_inc;
            cnt_d   = '0;
            grant_d = pick_found ? pick_idx : grant_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (clear_i) begin
      state_d   = ARB_IDLE;
      grant_d   = '0;
      cnt_d     = '0;
      rr_d      = '0;
      rdy       = '0;
      pop_valid = 1'b0;
      pop_data  = '0;
      pop_strb  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  assign pop_o.valid = pop_valid;
  assign pop_o.data  = pop_data;
  assign pop_o.strb  = pop_strb;

  assign flags_o.busy      = (state_q == ARB_BURST);
  assign flags_o.grant     = 8'(grant_q);
  assign flags_o.burst_cnt = 8'(cnt_q);

endmodule

// File: tb/tb_hwpe_stream_fifo_drain_arbiter.sv
// Scoreboard bench for the drain arbiter: per-source item queues drive the inputs,
// a transaction-level round-robin model predicts the merged beat stream.
module tb_hwpe_stream_fifo_drain_arbiter;
  import hwpe_stream_package::*;

  localparam int NB = 3;
  localparam int BL = 4;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int W  = 2 + 2 + SW + DW;

  typedef struct packed {
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } item_t;

  // ---------------- clock / reset ----------------
  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic clear_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [NB-1:0] push_valid;
  logic [NB-1:0] push_ready;
  logic [DW-1:0] push_data [NB];
  logic [SW-1:0] push_strb [NB];
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [SW-1:0] pop_strb;
  flags_arb_t    flags;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) push_if [NB-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) pop_if ();

  for (genvar i = 0; i < NB; i++) begin : g_conn
    assign push_if[i].valid = push_valid[i];
    assign push_if[i].data  = push_data[i];
    assign push_if[i].strb  = push_strb[i];
    assign push_ready[i]    = push_if[i].ready;
  end
  assign pop_valid    = pop_if.valid;
  assign pop_data     = pop_if.data;
  assign pop_strb     = pop_if.strb;
  assign pop_if.ready = pop_ready;

  hwpe_stream_fifo_drain_arbiter #(
    .NB_IN      (NB),
    .DATA_WIDTH (DW),
    .STRB_WIDTH (SW),
    .BURST_LEN  (BL)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push_if),
    .pop_o   (pop_if),
    .flags_o (flags)
  );

  // ---------------- shared bench state ----------------
  item_t          src_q [NB][$];
  logic [W-1:0]   exp_q[$];
  int             beat_cyc[$];
  bit             rdy_pat[$];
  bit             rdy_rand = 1'b0;
  int             mdl_rr   = 0;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: grant the next non-empty source after the last grant, take up to BL items.
  function automatic void predict();
    item_t q [NB][$];
    int    rr;
    int    g;
    int    n;
    bit    any;
    item_t it;
    for (int i = 0; i < NB; i++) q[i] = src_q[i];
    rr  = mdl_rr;
    any = 1'b1;
    while (any) begin
      g = -1;
      for (int k = 0; k < NB; k++) begin
        if (g < 0 && q[(rr + k) % NB].size() > 0) g = (rr + k) % NB;
      end
      if (g < 0) begin
        any = 1'b0;
      end else begin
        n = (q[g].size() < BL) ? q[g].size() : BL;
        for (int p = 0; p < n; p++) begin
          it = q[g].pop_front();
          exp_q.push_back({2'(g), 2'(p), it});
        end
        rr = (g + 1) % NB;
      end
    end
    mdl_rr = rr;
  endfunction

  // ---------------- driver ----------------
  initial begin
    bit [NB-1:0] hs;
    item_t       tmp;
    push_valid = '0;
    pop_ready  = 1'b1;
    for (int i = 0; i < NB; i++) begin
      push_data[i] = '0;
      push_strb[i] = '0;
    end
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < NB; i++) hs[i] = push_valid[i] && push_ready[i];
      @(posedge clk_i);
      #1;
      for (int i = 0; i < NB; i++) begin
        if (hs[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
        if (src_q[i].size() > 0) begin
          push_valid[i] = 1'b1;
          push_data[i]  = src_q[i][0].data;
          push_strb[i]  = src_q[i][0].strb;
        end else begin
          push_valid[i] = 1'b0;
          push_data[i]  = '0;
          push_strb[i]  = '0;
        end
      end
      if (rdy_pat.size() > 0) pop_ready = rdy_pat.pop_front();
      else if (rdy_rand)      pop_ready = ($urandom_range(0, 99) < 70);
      else                    pop_ready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (!pop_valid) check(pop_data == '0 && pop_strb == '0, "idle_data_zero", {pop_strb, pop_data}, 0);
        if (pop_valid && pop_ready) begin
          beat_cyc.push_back(cyc);
          act = {flags.grant[1:0], flags.burst_cnt[1:0], pop_strb, pop_data};
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", act, 0);
          end else begin
            e = exp_q.pop_front();
            check(act == e, "beat", act, e);
          end
          check(flags.busy && (push_ready == (3'b001 << flags.grant[1:0])), "ready_onehot",
                {flags.busy, push_ready}, {1'b1, 3'b001 << flags.grant[1:0]});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic load(input int s, input int n);
    item_t it;
    for (int k = 0; k < n; k++) begin
      it.data = $urandom();
      it.strb = SW'($urandom_range(0, 15));
      src_q[s].push_back(it);
    end
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < NB; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input int budget);
    int t = 0;
    while (!(exp_q.size() == 0 && queues_empty() && !flags.busy) && t < budget) begin
      tick();
      t++;
    end
    check(t < budget, "drain_timeout", t, budget);
  endtask

  task automatic check_beats(input string name, input int l, input int n);
    check(beat_cyc.size() == n, name, beat_cyc.size(), n);
    if (beat_cyc.size() == n) begin
      check(beat_cyc[0] - l == 2, "first_beat_latency", beat_cyc[0] - l, 2);
      check(beat_cyc[n-1] - beat_cyc[0] == n - 1, "no_bubble", beat_cyc[n-1] - beat_cyc[0], n - 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int l;
    int t;
    item_t it;

    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check(!pop_valid && push_ready == '0 && flags == '0, "reset_idle",
            {pop_valid, push_ready, flags}, 0);
    end

    // All three sources continuously valid, 8 items each.
    tick();
    beat_cyc.delete();
    l = cyc;
    for (int s = 0; s < NB; s++) load(s, 8);
    predict();
    wait_idle(300);
    check_beats("full_rr_count", l, 24);

    // Drain release by src1 after 2 beats.
    tick();
    load(1, 2);
    predict();
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    check(t < 50, "drain_wait", t, 50);
    tick();
    check(flags.busy && !pop_valid, "drain_bubble", {flags.busy, pop_valid}, 2'b10);
    tick();
    check(!flags.busy, "drain_idle", flags.busy, 0);

    // rr now points past src1: src2 must beat src0.
    tick();
    load(0, 2);
    load(2, 2);
    predict();
    wait_idle(100);

    // Backpressure on src2; leading 1 covers the arbitration bubble.
    tick();
    beat_cyc.delete();
    l = cyc;
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load(2, 4);
    predict();
    wait_idle(100);
    check(beat_cyc.size() == 4, "bp_count", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check(beat_cyc[3] - beat_cyc[0] == 5, "bp_span", beat_cyc[3] - beat_cyc[0], 5);

    // Single requester, 9 beats: 4+4+1 back to back.
    tick();
    beat_cyc.delete();
    l = cyc;
    load(0, 9);
    predict();
    wait_idle(100);
    check_beats("single_count", l, 9);

    // Clear on the second beat of a src1 burst.
    tick();
    load(1, 4);
    it = src_q[1][0];
    exp_q.push_back({2'd1, 2'd0, it});
    tick();
    load(0, 3);
    tick();
    @(posedge clk_i);
    #1 clear_i = 1'b1;
    @(negedge clk_i);
    #1;
    check(!pop_valid && push_ready == '0, "clear_no_beat", {pop_valid, push_ready}, 0);
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    @(negedge clk_i);
    #1;
    check(flags == '0 && !pop_valid, "clear_idle", {flags, pop_valid}, 0);
    check(src_q[1].size() == 3, "clear_src1_left", src_q[1].size(), 3);
    mdl_rr = 0;
    predict();
    wait_idle(100);

    // Randomized rounds with random backpressure.
    rdy_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick();
      for (int s = 0; s < NB; s++) load(s, $urandom_range(0, 10));
      predict();
      wait_idle(600);
    end

    repeat (3) tick();
    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
